// File: rtl/control_pipeline_hazard.sv
// Pipelined MIPS main control: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall, freeze and flush handling. Hazard logic built only with HAZARD_DETECT_EN.
module control_pipeline_hazard #(
    parameter int REG_W           = 5,
    parameter int LOAD_USE_STALLS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ext_stall,
    input  logic             flush,
    output logic             id_jump,
    output logic             id_extend_sel,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             ex_regdst,
    output logic             ex_alusrc,
    output logic             ex_branch,
    output logic [1:0]       ex_aluop,
    output logic             mem_read,
    output logic             mem_write,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic             illegal_op
);

    localparam logic [5:0] OP_R     = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef struct packed {
        logic       regdst;
        logic [1:0] aluop;
        logic       alusrc;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
    } ctrl_t;

    ctrl_t      dec;
    logic       dec_ext;
    logic       dec_jump;
    logic       dec_illegal;

    ctrl_t      idex_q, idex_d;
    logic [3:0] exmem_q, exmem_d;   // {memread, memwrite, regwrite, memtoreg}
    logic [1:0] memwb_q, memwb_d;   // {regwrite, memtoreg}
    logic       illegal_q, illegal_d;

    logic       hazard;
    logic       stall;

    always_comb begin
        dec         = '0;
        dec_ext     = 1'b0;
        dec_jump    = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                dec.regdst   = 1'b1;
                dec.aluop    = 2'b10;
                dec.regwrite = 1'b1;
            end
            OP_ADDIU: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec_ext      = 1'b1;
            end
            OP_LW: begin
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
                dec_ext      = 1'b1;
            end
            OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec_ext      = 1'b1;
            end
            OP_BEQ: begin
                dec.aluop    = 2'b01;
                dec.branch   = 1'b1;
                dec_ext      = 1'b1;
            end
            OP_J: begin
                dec_jump     = 1'b1;
            end
            OP_ANDI: begin
                dec.aluop    = 2'b11;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            default: begin
                dec_illegal  = 1'b1;
            end
        endcase
    end

`ifdef HAZARD_DETECT_EN
    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_USE_STALLS - 1);

    logic [REG_W-1:0] idex_rt_q, idex_rt_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [REG_W-1:0] rs_diff;
    logic [REG_W-1:0] rt_diff;

    // Bitwise mismatch vectors; an all-zero vector means the fields are equal.
    for (genvar gi = 0; gi < REG_W; gi++) begin : g_cmp
        assign rs_diff[gi] = idex_rt_q[gi] ^ id_rs[gi];
        assign rt_diff[gi] = idex_rt_q[gi] ^ id_rt[gi];
    end

    // A fresh detection is suppressed while a previous stall is still counting down.
    assign hazard = idex_q.memread && ((rs_diff == '0) || (rt_diff == '0)) && (cnt_q == 2'd0);
    assign stall  = hazard || (cnt_q != 2'd0);

    always_comb begin
        cnt_d     = cnt_q;
        idex_rt_d = idex_rt_q;
        if (!ext_stall) begin
            if (flush) begin
                cnt_d     = 2'd0;
                idex_rt_d = '0;
            end else if (hazard) begin
                cnt_d     = STALL_RELOAD;
                idex_rt_d = '0;
            end else if (cnt_q != 2'd0) begin
                cnt_d     = cnt_q - 2'd1;
                idex_rt_d = '0;
            end else begin
                idex_rt_d = id_rt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 2'd0;
            idex_rt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            idex_rt_q <= idex_rt_d;
        end
    end
`else
    // Without detection the source fields and stall depth have no consumer.
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{id_rs, id_rt, 2'(LOAD_USE_STALLS)};
    assign hazard = 1'b0;
    assign stall  = 1'b0;
`endif

    always_comb begin
        idex_d    = idex_q;
        exmem_d   = exmem_q;
        memwb_d   = memwb_q;
        illegal_d = 1'b0;
        if (!ext_stall) begin
            exmem_d = {idex_q.memread, idex_q.memwrite, idex_q.regwrite, idex_q.memtoreg};
            memwb_d = exmem_q[1:0];
            if (flush || stall) begin
                idex_d = '0;
            end else begin
                idex_d    = dec;
                illegal_d = dec_illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q    <= '0;
            exmem_q   <= '0;
            memwb_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            idex_q    <= idex_d;
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
            illegal_q <= illegal_d;
        end
    end

    // A redirect must still load the new PC even if a load-use stall was pending.
    assign pc_write      = ~ext_stall & (flush | ~stall);
    assign if_id_write   = pc_write;
    assign id_jump       = dec_jump;
    assign id_extend_sel = dec_ext;

    assign ex_regdst   = idex_q.regdst;
    assign ex_aluop    = idex_q.aluop;
    assign ex_alusrc   = idex_q.alusrc;
    assign ex_branch   = idex_q.branch;
    assign mem_read    = exmem_q[3];
    assign mem_write   = exmem_q[2];
    assign wb_regwrite = memwb_q[1];
    assign wb_memtoreg = memwb_q[0];
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_control_pipeline_hazard.sv
// Directed bench for control_pipeline_hazard: decode table stream plus hand sequences
// for stall, flush, freeze, illegal opcode and reset corner cases.
module tb_control_pipeline_hazard;

    localparam logic [5:0] OP_R = 6'd0, OP_J = 6'd2, OP_BEQ = 6'd4, OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_ANDI = 6'd12, OP_LW = 6'd35, OP_SW = 6'd43;

`ifdef HAZARD_DETECT_EN
    localparam int EXP_STALLS = 2;
`else
    localparam int EXP_STALLS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [4:0] id_rs, id_rt;
    logic       ext_stall, flush;
    logic       id_jump, id_extend_sel, pc_write, if_id_write;
    logic       ex_regdst, ex_alusrc, ex_branch;
    logic [1:0] ex_aluop;
    logic       mem_read, mem_write, wb_regwrite, wb_memtoreg, illegal_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_pipeline_hazard #(.REG_W(5), .LOAD_USE_STALLS(2)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ext_stall(ext_stall), .flush(flush),
        .id_jump(id_jump), .id_extend_sel(id_extend_sel),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_aluop(ex_aluop),
        .mem_read(mem_read), .mem_write(mem_write),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .illegal_op(illegal_op)
    );

`ifdef HAZARD_DETECT_EN
    logic       f_id_jump, f_id_extend_sel, f_pc_write, f_if_id_write;
    logic       f_ex_regdst, f_ex_alusrc, f_ex_branch;
    logic [1:0] f_ex_aluop;
    logic       f_mem_read, f_mem_write, f_wb_regwrite, f_wb_memtoreg, f_illegal_op;

    control_pipeline_hazard #(.REG_W(5), .LOAD_USE_STALLS(3)) dut3 (
        .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ext_stall(ext_stall), .flush(flush),
        .id_jump(f_id_jump), .id_extend_sel(f_id_extend_sel),
        .pc_write(f_pc_write), .if_id_write(f_if_id_write),
        .ex_regdst(f_ex_regdst), .ex_alusrc(f_ex_alusrc), .ex_branch(f_ex_branch), .ex_aluop(f_ex_aluop),
        .mem_read(f_mem_read), .mem_write(f_mem_write),
        .wb_regwrite(f_wb_regwrite), .wb_memtoreg(f_wb_memtoreg), .illegal_op(f_illegal_op)
    );
`endif

    typedef struct {
        logic [5:0] op;
        logic [7:0] vec;   // {RegDst, ALUOp[1:0], ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg}
        logic       br;
        logic       ext;
        logic       jmp;
    } vec_t;

    vec_t       tbl [7];
    logic [3:0] obs_ex  [10];
    logic       obs_br  [10];
    logic [1:0] obs_mem [10];
    logic [1:0] obs_wb  [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        opcode = op;
        id_rs  = rs;
        id_rt  = rt;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        ext_stall = 1'b0;
        flush     = 1'b0;
        set_in(OP_R, 5'd0, 5'd0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    // LW writing $8 followed by an R-type with the given sources.
    task automatic lu_seq(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                          input int exp_stalls);
        int n;
        n = 0;
        do_reset;
        set_in(OP_LW, 5'd1, 5'd8);
        tick;
        set_in(OP_R, rs, rt);
        #1;
        while (pc_write === 1'b0 && n < 6) begin
            chk({tag, "_ifid_we"}, {31'd0, if_id_write}, 32'd0);
            n++;
            tick;
            chk({tag, "_bubble"}, {28'd0, ex_regdst, ex_aluop, ex_alusrc}, 32'd0);
        end
        chk({tag, "_stall_cycles"}, n, exp_stalls);
        tick;
        chk({tag, "_dep_ex"}, {28'd0, ex_regdst, ex_aluop, ex_alusrc}, 32'b1100);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;

        tbl[0] = '{OP_R,     8'b11000010, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{OP_ADDIU, 8'b00010010, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{OP_LW,    8'b00011011, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{OP_SW,    8'b00010100, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{OP_BEQ,   8'b00100000, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{OP_J,     8'b00000000, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{OP_ANDI,  8'b01110010, 1'b0, 1'b0, 1'b0};

        // Reset state
        do_reset;
        chk("reset_regs", {23'd0, ex_regdst, ex_aluop, ex_alusrc, ex_branch, mem_read, mem_write,
                           wb_regwrite, wb_memtoreg, illegal_op}, 32'd0);
        #1;
        chk("reset_pc_write", {31'd0, pc_write}, 32'd1);
        chk("reset_ifid_write", {31'd0, if_id_write}, 32'd1);

        // Decode stream with per-stage latency
        for (int c = 0; c < 10; c++) begin
            if (c < 7) set_in(tbl[c].op, 5'(c + 10), 5'(c + 20));
            else       set_in(OP_R, 5'd30, 5'd31);
            #1;
            if (c < 7) begin
                chk($sformatf("jump_op%0d", tbl[c].op), {31'd0, id_jump}, {31'd0, tbl[c].jmp});
                chk($sformatf("ext_op%0d", tbl[c].op), {31'd0, id_extend_sel}, {31'd0, tbl[c].ext});
                chk($sformatf("pcw_op%0d", tbl[c].op), {31'd0, pc_write}, 32'd1);
            end
            tick;
            obs_ex[c]  = {ex_regdst, ex_aluop, ex_alusrc};
            obs_br[c]  = ex_branch;
            obs_mem[c] = {mem_read, mem_write};
            obs_wb[c]  = {wb_regwrite, wb_memtoreg};
        end
        for (int i = 0; i < 7; i++) begin
            v = tbl[i].vec;
            chk($sformatf("ex_op%0d", tbl[i].op), {28'd0, obs_ex[i]}, {28'd0, v[7], v[6:5], v[4]});
            chk($sformatf("br_op%0d", tbl[i].op), {31'd0, obs_br[i]}, {31'd0, tbl[i].br});
            chk($sformatf("mem_op%0d", tbl[i].op), {30'd0, obs_mem[i+1]}, {30'd0, v[3], v[2]});
            chk($sformatf("wb_op%0d", tbl[i].op), {30'd0, obs_wb[i+2]}, {30'd0, v[1], v[0]});
        end

        // Load-use: rs match, rt match, no match
        lu_seq("lu_rs", 5'd8, 5'd9, EXP_STALLS);
        lu_seq("lu_rt", 5'd3, 5'd8, EXP_STALLS);
        lu_seq("lu_none", 5'd3, 5'd4, 0);

`ifdef HAZARD_DETECT_EN
        // Flush one cycle after detection with a 3-cycle stall depth
        do_reset;
        set_in(OP_LW, 5'd1, 5'd8);
        tick;
        set_in(OP_R, 5'd8, 5'd9);
        #1;
        chk("f3_detect_pcw", {31'd0, f_pc_write}, 32'd0);
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("f3_bubble", {27'd0, f_ex_regdst, f_ex_aluop, f_ex_alusrc, f_ex_branch}, 32'd0);
        chk("f3_pcw_after", {31'd0, f_pc_write}, 32'd1);
        tick;
        chk("f3_dep_ex", {28'd0, f_ex_regdst, f_ex_aluop, f_ex_alusrc}, 32'b1100);
`endif

        // Plain flush turns the ID instruction into a bubble
        do_reset;
        set_in(OP_R, 5'd1, 5'd2);
        tick;
        chk("fl_pre", {28'd0, ex_regdst, ex_aluop, ex_alusrc}, 32'b1100);
        set_in(OP_ANDI, 5'd3, 5'd4);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("fl_bubble", {28'd0, ex_regdst, ex_aluop, ex_alusrc}, 32'd0);
        tick;
        chk("fl_after", {28'd0, ex_regdst, ex_aluop, ex_alusrc}, 32'b0111);

        // Freeze for 4 cycles with a flush pulse inside
        do_reset;
        set_in(OP_R, 5'd10, 5'd20);
        tick;
        set_in(OP_LW, 5'd11, 5'd21);
        tick;
        set_in(OP_ADDIU, 5'd12, 5'd22);
        tick;
        set_in(OP_SW, 5'd13, 5'd23);
        ext_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            flush = (k == 1);
            #1;
            chk($sformatf("frz_pcw_%0d", k), {30'd0, pc_write, if_id_write}, 32'd0);
            tick;
            chk($sformatf("frz_hold_%0d", k),
                {24'd0, ex_regdst, ex_aluop, ex_alusrc, mem_read, mem_write, wb_regwrite, wb_memtoreg},
                {24'd0, 4'b0001, 2'b10, 2'b10});
            chk($sformatf("frz_illegal_%0d", k), {31'd0, illegal_op}, 32'd0);
        end
        ext_stall = 1'b0;
        flush     = 1'b0;
        tick;
        chk("frz_resume1",
            {24'd0, ex_regdst, ex_aluop, ex_alusrc, mem_read, mem_write, wb_regwrite, wb_memtoreg},
            {24'd0, 4'b0001, 2'b00, 2'b11});
        set_in(OP_R, 5'd14, 5'd24);
        tick;
        chk("frz_resume2", {28'd0, mem_read, mem_write, wb_regwrite, wb_memtoreg},
            {28'd0, 2'b01, 2'b10});

        // Illegal opcode
        do_reset;
        set_in(6'd63, 5'd1, 5'd2);
        #1;
        chk("ill_comb", {30'd0, id_jump, id_extend_sel}, 32'd0);
        tick;
        chk("ill_pulse", {31'd0, illegal_op}, 32'd1);
        chk("ill_ex_zero", {27'd0, ex_regdst, ex_aluop, ex_alusrc, ex_branch}, 32'd0);
        set_in(OP_R, 5'd3, 5'd4);
        tick;
        chk("ill_pulse_end", {31'd0, illegal_op}, 32'd0);
        chk("ill_mem_zero", {30'd0, mem_read, mem_write}, 32'd0);

        // Reset in the middle of a load-use stall
        do_reset;
        set_in(OP_LW, 5'd1, 5'd8);
        tick;
        set_in(OP_R, 5'd8, 5'd9);
        tick;
        rst = 1'b1;
        tick;
        chk("rst_mid_regs", {23'd0, ex_regdst, ex_aluop, ex_alusrc, ex_branch, mem_read, mem_write,
                             wb_regwrite, wb_memtoreg, illegal_op}, 32'd0);
        chk("rst_mid_pcw", {31'd0, pc_write}, 32'd1);
        rst = 1'b0;
        tick;
        chk("rst_mid_dep", {28'd0, ex_regdst, ex_aluop, ex_alusrc}, 32'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_pipeline_hazard.md
# control_pipeline_hazard

Pipelined MIPS main control with integrated stage registers and load-use hazard control. It decodes the ID-stage opcode into the control vector and carries the fields through the ID/EX, EX/MEM and MEM/WB control registers. It generates PC/IF-ID write enables, bubble insertion for load-use hazards with a configurable stall depth, external freeze and branch flush. It sits between the IF/ID register and the datapath stage muxes, and replaces the purely combinational control decoder.

## Interface
- REG_W, 5: register-address width of rs/rt compare fields.
- LOAD_USE_STALLS, 1: bubble cycles per load-use hazard; legal range 1..3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- opcode  in  6  IF/ID instruction[31:26].
- id_rs, id_rt  in  REG_W  IF/ID source fields.
- ext_stall  in  1  global freeze (memory wait).
- flush  in  1  branch-taken/redirect from EX; cancels ID/EX contents.
- id_jump  out  1  combinational: opcode==J.
- id_extend_sel  out  1  combinational: 1 = sign-extend, 0 = zero-extend.
- pc_write, if_id_write  out  1  combinational enables.
- ex_regdst, ex_alusrc, ex_branch  out  1  ID/EX register.
- ex_aluop  out  2  ID/EX register.
- mem_read, mem_write  out  1  EX/MEM register.
- wb_regwrite, wb_memtoreg  out  1  MEM/WB register.
- illegal_op  out  1  registered one-cycle pulse.

## Operation
- The decode vector is {RegDst, ALUOp[1:0], ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg}, plus Branch and ExtendSel. Decoded don't-care bits are driven to 0.
  - R (0): 1_10_0_0_0_1_0, ExtendSel 0.
  - ADDIU (9): 0_00_1_0_0_1_0, ExtendSel 1.
  - LW (35): 0_00_1_1_0_1_1, ExtendSel 1.
  - SW (43): 0_00_1_0_1_0_0, ExtendSel 1.
  - BEQ (4): 0_01_0_0_0_0_0, Branch 1, ExtendSel 1.
  - J (2): all zero; id_jump 1.
  - ANDI (12): 0_11_1_0_0_1_0, ExtendSel 0.
  - Other opcodes: all-zero bubble; illegal_op pulses on the cycle the bubble is latched into ID/EX.
- Load-use hazard: ID/EX MemRead==1 and ID/EX rt equals id_rs or id_rt, with REG_W-bit compare. Register 0 is compared like any other register.
  - On detection: pc_write=0 and if_id_write=0; a bubble is latched into ID/EX; stall counter is loaded with LOAD_USE_STALLS-1.
  - While the counter is nonzero: keep stalling, insert a bubble, decrement.
- flush: the next ID/EX value is a bubble; the stall counter is cleared.
- ext_stall: ID/EX, EX/MEM, MEM/WB and the counter all hold; pc_write=0, if_id_write=0; illegal_op=0.
- Priority, highest first: rst, ext_stall, flush, load-use/counter, normal advance.
  - A flush asserted during ext_stall is ignored; the producer holds it.
- EX/MEM and MEM/WB advance every non-frozen cycle. Bubbles propagate as zeros.

## Timing
- Reset: every registered output and the counter are 0. pc_write and if_id_write are 1 after reset when no stall condition holds.
- Latency from opcode in ID: ex_* at +1 cycle, mem_* at +2, wb_* at +3.
- Combinational outputs (id_jump, id_extend_sel, pc_write, if_id_write) respond in the same cycle as their inputs.
- A load-use hazard costs exactly LOAD_USE_STALLS cycles with pc_write=0. The dependent instruction enters ID/EX on cycle LOAD_USE_STALLS+1 after detection, with ext_stall low throughout.
- Back-to-back load-use hazards each stall independently. A hazard is not re-detected while the counter is nonzero.
- rst mid-stall clears the counter; pc_write=1 on the next cycle.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection and the stall counter are compiled in.
- HAZARD_DETECT_EN undefined: no compare and no counter. pc_write = if_id_write = ~ext_stall. LOAD_USE_STALLS is ignored. The compiler or software must insert NOPs after loads.

## Test plan
- Reset, then the sequence R, ADDIU, LW, SW, BEQ, J, ANDI -> ex_* shows 8'b11000010, 00010010, 00011011, 00010100, 00100000, 00000000, 01110010 on successive cycles. mem_* and wb_* follow at +1 and +2 cycles.
- LW writing $8, then R reading rs=$8, LOAD_USE_STALLS=2 -> pc_write is low for 2 cycles and two zero bubbles are seen in ID/EX. The R vector appears at ex_* on the 3rd cycle.
- Same as above with rt match only, and with no match -> stall of 2 cycles and 0 cycles respectively.
- flush asserted on the cycle after a load-use detection (LOAD_USE_STALLS=3) -> the counter clears, pc_write=1 the next cycle, and ID/EX holds a bubble.
- ext_stall high for 4 cycles mid-stream, with flush also pulsed during it -> all ex/mem/wb outputs are frozen, the flush has no effect, and the stream resumes unchanged.
- Opcode 63 -> zero vector latched into ID/EX and illegal_op high for exactly one cycle. Also: rst asserted mid-stall -> all outputs are 0 on the next edge.
